// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the serial adder family:
//   - FSM state encoding (ST_IDLE / ST_RUN / ST_DONE)
//   - add/sub mode constants
//   - helper that sizes the digit counter (ceil(log2(n)), never below 1)
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width needed to count 0..n-1. A single-digit operation still gets a
  // one-bit counter so the RTL never declares a zero-width vector.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell.
//   Ports: a_i, b_i, c_i (in); s_o, c_o (out).
//
// digit_adder
//   DIGIT-wide ripple of full_adder cells. Purely combinational.
//   Ports:
//     a_d, b_d  in  DIGIT  operand digits
//     c_in      in  1      carry into bit 0
//     s_d       out DIGIT  sum digit
//     c_out     out 1      carry out of bit DIGIT-1
//     c_msb_in  out 1      carry into bit DIGIT-1 (overflow detection)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);
  // carry[i] is the carry into bit i; carry[DIGIT] leaves the digit.
  logic [DIGIT:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_d[i]),
      .b_i (b_d[i]),
      .c_i (carry[i]),
      .s_o (s_d[i]),
      .c_o (carry[i+1])
    );
  end

  assign c_out    = carry[DIGIT];
  assign c_msb_in = carry[DIGIT-1];
endmodule

// File: rtl/serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// serial_adder_nbit
//   Multi-cycle adder/subtractor. Processes DIGIT bits per clock, LSB first,
//   over N = WIDTH/DIGIT RUN cycles, then pulses done for one cycle.
//   Subtraction is a + ~b + ~cin, so in sub mode cout is the inverted borrow.
//   Ports:
//     clk    in  1      clock, rising edge
//     rst    in  1      synchronous active-high reset
//     start  in  1      request, accepted in IDLE or DONE only
//     mode   in  1      0 = a+b+cin, 1 = a-b-cin
//     a, b   in  WIDTH  operands, sampled on the accepting edge
//     cin    in  1      carry-in / borrow-in, sampled on the accepting edge
//     busy   out 1      high while in RUN
//     done   out 1      one-cycle pulse, result valid
//     s      out WIDTH  result, held until the next done
//     cout   out 1      raw carry out of the MSB
//     ovf    out 1      two's-complement overflow
// ---------------------------------------------------------------------------
module serial_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int                 N     = WIDTH / DIGIT;
  localparam int                 CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic [WIDTH-1:0]   a_d, b_d, sum_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0]   s_q;

  logic [DIGIT-1:0]   dig_s;
  logic               dig_cout, dig_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_d      (a_q[DIGIT-1:0]),
    .b_d      (b_q[DIGIT-1:0]),
    .c_in     (carry_q),
    .s_d      (dig_s),
    .c_out    (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // Operand registers drain LSB-first; the sum digit enters at the MSB end
  // so after N shifts the whole result is aligned. The concatenation form
  // keeps the shift legal when DIGIT == WIDTH.
  logic [WIDTH+DIGIT-1:0] sum_cat;
  assign sum_cat = {dig_s, sum_q};
  assign sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign a_d     = a_q >> DIGIT;
  assign b_d     = b_q >> DIGIT;

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking = would let later lines see updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= (mode == MODE_SUB) ? ~b : b;
            carry_q <= (mode == MODE_SUB) ? ~cin : cin;
            sum_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= sum_d;
            cout_q  <= dig_cout;
            ovf_q   <= dig_cmsb ^ dig_cout;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_nbit
//   Four DUT instances (DIGIT = 1, 2, 4, 8; WIDTH = 8) share one stimulus
//   stream. Directed scenarios look at the DIGIT=2 instance; the random sweep
//   compares every instance with an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_adder_nbit;

  localparam int W = 8;
  localparam int NI = 4;
  localparam int MAIN = 1;          // DIGIT=2 instance, N=4

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a, b;
  logic         cin;

  logic [NI-1:0] busy_w, done_w, cout_w, ovf_w;
  logic [W-1:0]  s_w [NI];

  int total = 0;
  int bad   = 0;

  // Per-instance capture filled by run_op.
  int           lat_r  [NI];
  int           busy_r [NI];
  logic [W-1:0] s_r    [NI];
  logic         cout_r [NI];
  logic         ovf_r  [NI];

  int n_of [NI] = '{8, 4, 2, 1};

  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy_w[0]), .done(done_w[0]), .s(s_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
  serial_adder_nbit #(.WIDTH(W), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy_w[1]), .done(done_w[1]), .s(s_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
  serial_adder_nbit #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy_w[2]), .done(done_w[2]), .s(s_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));
  serial_adder_nbit #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy_w[3]), .done(done_w[3]), .s(s_w[3]), .cout(cout_w[3]), .ovf(ovf_w[3]));

  // Reference: plain integer arithmetic. cout is "no unsigned wrap below 0"
  // for sub, "result exceeded 255" for add; ovf is signed range violation.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic mmode);
    res_t r;
    int ua, ub, sa, sb, ci, u, sg;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ci = mcin ? 1 : 0;
    if (!mmode) begin
      u  = ua + ub + ci;
      sg = sa + sb + ci;
      r.cout = (u > 255);
    end else begin
      u  = ua - ub - ci;
      sg = sa - sb - ci;
      r.cout = (ua >= ub + ci);
    end
    r.s   = u[W-1:0];
    r.ovf = (sg > 127) || (sg < -128);
    return r;
  endfunction

  // Launch one operation on all instances and record latency, busy cycles
  // and the result seen on each instance's done pulse. lat_r stays -1 if an
  // instance never finishes within the budget.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic ocin, input logic omode);
    bit all_done;
    for (int k = 0; k < NI; k++) begin
      lat_r[k] = -1;
      busy_r[k] = 0;
    end
    @(negedge clk);
    a = oa; b = ob; cin = ocin; mode = omode; start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); mode = 1'($urandom);
      end
      all_done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (lat_r[k] < 0) begin
          if (busy_w[k]) busy_r[k]++;
          if (done_w[k]) begin
            lat_r[k]  = cyc;
            s_r[k]    = s_w[k];
            cout_r[k] = cout_w[k];
            ovf_r[k]  = ovf_w[k];
          end
        end
        if (lat_r[k] < 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++;
      if ({busy_w[k], done_w[k], s_w[k], cout_w[k], ovf_w[k]} !== '0) begin
        bad++;
        $display("FAIL reset_state inst=%0d busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
                 k, busy_w[k], done_w[k], s_w[k], cout_w[k], ovf_w[k]);
      end
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] ta,
                               input logic [W-1:0] tb, input logic tcin, input logic tmode,
                               input logic [W-1:0] es, input logic ecout, input logic eovf);
    run_op(ta, tb, tcin, tmode);
    total++;
    if (lat_r[MAIN] !== 5) begin
      bad++; $display("FAIL %s latency got=%0d expected=5", name, lat_r[MAIN]);
    end
    total++;
    if (busy_r[MAIN] !== 4) begin
      bad++; $display("FAIL %s busy_cycles got=%0d expected=4", name, busy_r[MAIN]);
    end
    total++;
    if ({s_r[MAIN], cout_r[MAIN], ovf_r[MAIN]} !== {es, ecout, eovf}) begin
      bad++;
      $display("FAIL %s result got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
               name, s_r[MAIN], cout_r[MAIN], ovf_r[MAIN], es, ecout, eovf);
    end
  endtask

  task automatic test_ignore_start_in_run();
    int ndone, first;
    res_t exp_r;
    logic [W-1:0] got_s;
    ndone = 0; first = -1; got_s = '0;
    exp_r = model(8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; mode = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) begin
        a = 8'hA5; b = 8'h5A; cin = 1'b1; mode = 1'b1; start = 1'b1;
      end
      if (cyc == 3) start = 1'b0;
      if (done_w[MAIN]) begin
        ndone++;
        if (first < 0) begin first = cyc; got_s = s_w[MAIN]; end
      end
    end
    total++;
    if (ndone !== 1 || first !== 5) begin
      bad++; $display("FAIL ignore_start dones=%0d first_at=%0d expected dones=1 first_at=5", ndone, first);
    end
    total++;
    if (got_s !== exp_r.s) begin
      bad++; $display("FAIL ignore_start result got s=%h expected s=%h", got_s, exp_r.s);
    end
  endtask

  task automatic test_back_to_back();
    int ndone, first, second;
    res_t e1, e2;
    logic [W-1:0] s1, s2;
    ndone = 0; first = -1; second = -1; s1 = '0; s2 = '0;
    e1 = model(8'h77, 8'h11, 1'b1, 1'b0);
    e2 = model(8'h40, 8'hC3, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b1; mode = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1 || (first > 0 && cyc == first + 1)) start = 1'b0;
      if (done_w[MAIN]) begin
        ndone++;
        if (first < 0) begin
          first = cyc; s1 = s_w[MAIN];
          a = 8'h40; b = 8'hC3; cin = 1'b0; mode = 1'b1; start = 1'b1;
        end else if (second < 0) begin
          second = cyc; s2 = s_w[MAIN];
        end
      end
    end
    total++;
    if (ndone !== 2 || first !== 5 || second !== 10) begin
      bad++;
      $display("FAIL back_to_back dones=%0d at=%0d,%0d expected dones=2 at=5,10", ndone, first, second);
    end
    total++;
    if (s1 !== e1.s || s2 !== e2.s) begin
      bad++; $display("FAIL back_to_back results got %h,%h expected %h,%h", s1, s2, e1.s, e2.s);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'h3C; b = 8'h45; cin = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;   // RUN cycle 1
    @(negedge clk);                 // RUN cycle 2
    @(negedge clk); rst = 1'b1;     // RUN cycle 3
    @(negedge clk); rst = 1'b0;
    total++;
    if ({busy_w[MAIN], done_w[MAIN], s_w[MAIN], cout_w[MAIN], ovf_w[MAIN]} !== '0) begin
      bad++;
      $display("FAIL reset_mid_run busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               busy_w[MAIN], done_w[MAIN], s_w[MAIN], cout_w[MAIN], ovf_w[MAIN]);
    end
    repeat (8) begin
      @(negedge clk);
      if (done_w[MAIN] || busy_w[MAIN]) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++; $display("FAIL reset_mid_run activity_after_abort got=%0d expected=0", ndone);
    end
    test_directed("after_reset", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_random_sweep(input int iters);
    res_t e;
    logic [W-1:0] ra, rb;
    logic rc, rm;
    for (int it = 0; it < iters; it++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      if (it < 4) begin           // pin a few corner operands
        ra = (it[0]) ? 8'h80 : 8'h7F;
        rb = (it[1]) ? 8'hFF : 8'h00;
      end
      e = model(ra, rb, rc, rm);
      run_op(ra, rb, rc, rm);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (lat_r[k] !== n_of[k] + 1 || busy_r[k] !== n_of[k]) begin
          bad++;
          $display("FAIL sweep_timing inst=%0d it=%0d lat=%0d busy=%0d expected lat=%0d busy=%0d",
                   k, it, lat_r[k], busy_r[k], n_of[k] + 1, n_of[k]);
        end
        total++;
        if ({s_r[k], cout_r[k], ovf_r[k]} !== {e.s, e.cout, e.ovf}) begin
          bad++;
          $display("FAIL sweep_result inst=%0d a=%h b=%h cin=%b mode=%b got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                   k, ra, rb, rc, rm, s_r[k], cout_r[k], ovf_r[k], e.s, e.cout, e.ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("add_3c_45", 8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
    test_directed("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    test_directed("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    test_directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    test_ignore_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Parametrised multi-cycle adder/subtractor; next generation of the fixed 4-bit ripple adder.
- Processes DIGIT bits per clock, LSB-first, over N = WIDTH/DIGIT cycles, trading latency for area.
- Adds a start/busy/done handshake, an add/sub mode, signed overflow, and held result registers.
- Sits beside the combinational adders in the arithmetic datapath; drives ALU-style consumers that sample on done.

Parameters:
- WIDTH, 8: operand/result width in bits. Legal when WIDTH >= 2.
- DIGIT, 2: bits processed per cycle. Legal when 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- mode  in  1  0 = add (a+b+cin); 1 = sub (a-b-cin).
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- cin  in  1  carry-in (add) or borrow-in (sub), sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- s  out  WIDTH  result, held until the next done.
- cout  out  1  raw carry-out. In sub mode, borrow = ~cout.
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state goes to IDLE; s=0, cout=0, ovf=0, busy=0, done=0; counter and shift registers cleared.
- Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE or DONE with start=1 -> RUN. Latch a, b_eff = mode ? ~b : b, and carry = mode ? ~cin : cin. Clear the digit counter.
  - RUN: each edge adds the low DIGIT bits of the A and B_eff shift registers plus the carry.
    - Sum digit shifts into the MSB end of the sum register.
    - Carry register updates; counter increments.
  - RUN, on the edge processing digit N-1 -> DONE. On that edge:
    - s <= final sum
    - cout <= final carry
    - ovf <= carry_into_msb ^ final carry
  - DONE lasts one cycle with done=1. Without start -> IDLE; with start -> RUN (back-to-back, throughput N+1 cycles).
- Latency: if start is accepted at edge 0, busy is high after edges 0..N-1, and done is high for exactly the cycle after edge N.
- start during RUN is ignored. Operand inputs are don't-care except on the accepting edge.
- s/cout/ovf change only on the RUN->DONE edge or on reset; they are stable through IDLE and the next RUN.
- All arithmetic is modulo 2^WIDTH. The carry into the MSB comes from the digit adder's internal carry at bit DIGIT-1 of the final digit.
- DIGIT == WIDTH gives N=1: single RUN cycle, identical state sequence.

Decomposition:
- Shared package (adder_pkg):
  - state encoding constants ST_IDLE / ST_RUN / ST_DONE
  - MODE_ADD / MODE_SUB constants
  - counter-width function clog2(WIDTH/DIGIT), min 1
- One sub-module: digit_adder, a DIGIT-wide ripple of the existing full_adder cells.
  - Inputs: a_d, b_d, c_in. Outputs: s_d, c_out, c_msb_in.
  - Purely combinational. The FSM, counter and shift registers stay in serial_adder_nbit.

Test Plan (WIDTH=8, DIGIT=2, N=4 unless noted):
- Add 0x3C + 0x45, cin=0 -> done 5 cycles after start edge; s=0x81, cout=0, ovf=1; busy high exactly 4 cycles.
- Add 0xFF + 0x01, cin=1 -> s=0x01, cout=1, ovf=0.
- Sub 0x10 - 0x20, cin=0 -> s=0xF0, cout=0 (borrow), ovf=0. Then sub 0x80 - 0x01 -> s=0x7F, cout=1, ovf=1.
- Handshake: pulse start again in RUN cycle 2 with different operands -> ignored; single done with the first result. Assert start in the DONE cycle -> accepted; second done exactly 5 cycles later.
- Assert rst for one cycle during RUN cycle 3 -> next cycle all outputs 0, busy=0, no done. Fresh start then completes normally.
- Sweep DIGIT in {1, 2, 4, 8}: 1000 random a/b/cin/mode vs. behavioural model. s/cout/ovf match; latency = N+1 cycles in every case.
